// File: rtl/sme_pkg.sv
// Shared SME definitions: FSM state encoding and share/pair count derivations.
package sme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sme_state_e;

  // Number of unordered share pairs for a given share count.
  function automatic int unsigned sme_npair(input int unsigned smax);
    return (smax * (smax - 1)) / 2;
  endfunction

  // Random words consumed per request slot: one per share plus one per pair.
  function automatic int unsigned sme_rmax(input int unsigned smax);
    return smax + sme_npair(smax);
  endfunction

  // Counter/index width able to hold n-1, never narrower than one bit.
  function automatic int unsigned sme_cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sme_pair_seq.sv
// Maps the pair counter k onto the lexicographic share pair (i,j) and flags
// the final pair of a refresh.
module sme_pair_seq
  import sme_pkg::*;
#(
  parameter  int unsigned SMAX  = 3,
  localparam int unsigned NPAIR = sme_npair(SMAX),
  localparam int unsigned KW    = sme_cw(NPAIR),
  localparam int unsigned IW    = sme_cw(SMAX)
) (
  input  logic [KW-1:0] k,
  output logic [IW-1:0] pair_i,
  output logic [IW-1:0] pair_j,
  output logic [KW-1:0] pair_k,
  output logic          pair_last
);

  // Pair (a,b) with a<b sits at index a*(2*SMAX-a-1)/2 + (b-a-1) in
  // lexicographic order; select the one matching k.
  always_comb begin
    pair_i = '0;
    pair_j = '0;
    for (int unsigned a = 0; a < SMAX; a++) begin
      for (int unsigned b = a + 1; b < SMAX; b++) begin
        if (k == KW'((a * (2 * SMAX - a - 1)) / 2 + (b - a - 1))) begin
          pair_i = IW'(a);
          pair_j = IW'(b);
        end
      end
    end
  end

  assign pair_k    = k;
  assign pair_last = (NPAIR != 0) && (k == KW'(NPAIR - 1));

endmodule

// File: rtl/sme_mask_refresh.sv
// Masked-share refresh: latches SMAX shares, XORs one fresh random word into
// each share pair (one pair per cycle), then presents the refreshed shares.
module sme_mask_refresh
  import sme_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned SMAX  = 3,
  localparam int unsigned NPAIR = sme_npair(SMAX),
  localparam int unsigned RMAX  = sme_rmax(SMAX)
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  output logic                       g_clk_req,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SMAX-1:0][XLEN-1:0]  req_shares,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SMAX-1:0][XLEN-1:0]  rsp_shares,
  output logic                       rng_update,
  input  logic [RMAX-1:0][XLEN-1:0]  rng
);

  localparam int unsigned KW = sme_cw(NPAIR);
  localparam int unsigned IW = sme_cw(SMAX);

  sme_state_e                 state;
  logic [KW-1:0]              k;
  logic [SMAX-1:0][XLEN-1:0]  sh;
  logic [SMAX-1:0][XLEN-1:0]  sh_upd;
  logic [XLEN-1:0]            rng_word;
  logic [IW-1:0]              pair_i;
  logic [IW-1:0]              pair_j;
  logic [KW-1:0]              pair_k;
  logic                       pair_last;

  sme_pair_seq #(
    .SMAX (SMAX)
  ) u_pair_seq (
    .k         (k),
    .pair_i    (pair_i),
    .pair_j    (pair_j),
    .pair_k    (pair_k),
    .pair_last (pair_last)
  );

  // Select rng[k]; only the first NPAIR words can ever be chosen, the
  // remaining words of the RNG bus are ignored by construction.
  always_comb begin
    rng_word = '0;
    for (int unsigned r = 0; r < RMAX; r++) begin
      if ((r < NPAIR) && (KW'(r) == pair_k)) begin
        rng_word = rng[r];
      end
    end
  end

  // Apply the current pair: both shares of pair k absorb the same word, so
  // the XOR of all shares is unchanged.
  always_comb begin
    sh_upd = sh;
    for (int unsigned s = 0; s < SMAX; s++) begin
      if ((IW'(s) == pair_i) || (IW'(s) == pair_j)) begin
        sh_upd[s] = sh[s] ^ rng_word;
      end
    end
  end

  // Control FSM with share registers and pair counter; flush overrides all.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
      k     <= '0;
      sh    <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      k     <= '0;
      sh    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            sh    <= req_shares;
            k     <= '0;
            state <= (NPAIR == 0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          sh <= sh_upd;
          if (pair_last) begin
            state <= ST_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
            sh    <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          k     <= '0;
          sh    <= '0;
        end
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_DONE);
  assign rsp_shares = rsp_valid ? sh : '0;
  // The RNG source advances once, in the last pair cycle, unless aborted.
  assign rng_update = (state == ST_RUN) && pair_last && !flush;
  assign g_clk_req  = (state != ST_IDLE) || req_valid || flush;

endmodule

// File: doc/sme_mask_refresh.md
SME_MASK_REFRESH -- requirements
Module: sme_mask_refresh

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of each share and each random word.
REQ-002 SHALL have parameter SMAX, default 3, number of shares.
REQ-003 SHALL derive NPAIR = SMAX*(SMAX-1)/2 and RMAX = SMAX+NPAIR; neither SHALL be overridable.
REQ-004 g_clk  in  1  sole clock.
REQ-005 g_resetn  in  1  asynchronous, active-low reset.
REQ-006 g_clk_req  out  1  clock request to the clock gate.
REQ-007 flush  in  1  synchronous abort of any operation in progress.
REQ-008 req_valid  in  1  request shares are valid.
REQ-009 req_ready  out  1  block can accept a request.
REQ-010 req_shares  in  SMAX x XLEN  masked input shares.
REQ-011 rsp_valid  out  1  refreshed shares are valid.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_shares  out  SMAX x XLEN  refreshed shares.
REQ-014 rng_update  out  1  request to advance the random-word source.
REQ-015 rng  in  RMAX x XLEN  random words from the SME RNG.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE: req_ready=1; on req_valid&&req_ready, SHALL latch req_shares, clear pair counter k, and go to RUN (or to DONE if NPAIR=0).
REQ-018 RUN: one pair per cycle, pairs ordered lexicographically (0,1),(0,2),..,(1,2),..; pair k with shares (i,j) SHALL apply s[i]^=rng[k] and s[j]^=rng[k] in the same cycle.
REQ-019 RUN SHALL last exactly NPAIR cycles and then go to DONE; with accept at cycle t, rsp_valid SHALL rise at cycle t+NPAIR+1.
REQ-020 rng_update SHALL be 1 only in the final RUN cycle, so the source is advanced once per request; rng words rng[NPAIR..RM] SHALL be unused.
REQ-021 DONE: rsp_valid=1 and rsp_shares = share registers; on rsp_ready the block SHALL go to IDLE and clear the share registers to zero.
REQ-022 rsp_shares SHALL be driven as zero whenever rsp_valid=0; shares are never exposed mid-refresh.
REQ-023 req_ready SHALL be 0 in RUN and DONE; req_valid SHALL be ignored outside IDLE.
REQ-024 rsp_valid/rsp_shares SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-025 XOR of all output shares SHALL equal XOR of all latched input shares.
REQ-026 flush SHALL take priority over every other event: go to IDLE, zero the share registers and k, and deassert rng_update that cycle.
REQ-027 g_clk_req SHALL be (state!=IDLE) || req_valid || flush.
REQ-028 Registers SHALL be XLEN wide per share with no carries; k SHALL be wide enough for NPAIR-1 and SHALL never wrap past it.

Reset
REQ-029 Asserting g_resetn low SHALL immediately force IDLE, k=0, share registers=0, req_ready=1, rsp_valid=0, rng_update=0 and rsp_shares=0, including mid-RUN.

Structure
REQ-030 The shared package sme_pkg SHALL hold the FSM state enum and the NPAIR/RMAX derivation functions, shared with the RNG source.
REQ-031 One sub-module, sme_pair_seq, SHALL generate (i,j,k,last) from the pair counter; the rest of the logic SHALL be in sme_mask_refresh.

Verification
REQ-032 SMAX=3, shares {0x10,0x20,0x40}, rng[0..2]={1,2,4}, accept at t -> rsp_valid at t+4, shares {0x13,0x25,0x46}, rng_update=1 only at t+3.
REQ-033 Same stimulus with rsp_ready=0 for 5 cycles -> outputs held; then the handshake occurs, IDLE is re-entered, and req_ready=1 the next cycle.
REQ-034 flush asserted at t+2 -> IDLE at t+3, rsp_valid never rises, rng_update stays 0, and the share registers read 0.
REQ-035 g_resetn pulsed low mid-RUN -> all outputs reach their reset values asynchronously, and a new request is then processed correctly.
REQ-036 1000 random requests with random rng values -> XOR of output shares equals XOR of input shares every time, and exactly one rng_update occurs per request.
REQ-037 SMAX=1 build, share 0xDEADBEEF -> rsp_valid one cycle after accept with the share unchanged and rng_update never asserted.
